multiplier_sequencer: RTL

//   Upstream control stage for the sequential Multiplier. Accepts operand pairs on a valid/ready

---
 rtl/multiplier_sequencer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/multiplier_sequencer.sv
// Operand buffer + control FSM that drives a sequential multiplier and returns its product on a
// valid/ready port. Define MULTIPLIER_SEQUENCER_TIMEOUT_EN to enable the WAIT watchdog and sticky o_error.
module multiplier_sequencer #(
  parameter int BITS    = 4,
  parameter int TIMEOUT = 32
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [BITS-1:0]   i_multiplicand,
  input  logic [BITS-1:0]   i_multiplier,
  output logic              o_start,
  output logic [BITS-1:0]   o_mul_multiplicand,
  output logic [BITS-1:0]   o_mul_multiplier,
  input  logic              i_finished,
  input  logic [2*BITS-1:0] i_product,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [2*BITS-1:0] o_product,
  output logic              o_busy,
  output logic              o_error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic              buf_full_q, buf_full_d;
  logic [BITS-1:0]   buf_a_q,    buf_a_d;
  logic [BITS-1:0]   buf_b_q,    buf_b_d;
  logic [BITS-1:0]   mul_a_q,    mul_a_d;
  logic [BITS-1:0]   mul_b_q,    mul_b_d;
  logic              start_q,    start_d;
  logic              fin_q,      fin_d;
  logic              valid_q,    valid_d;
  logic [2*BITS-1:0] product_q,  product_d;
  logic              busy_q,     busy_d;
  logic              accept_s;
  logic              fin_rise_s;

`ifdef MULTIPLIER_SEQUENCER_TIMEOUT_EN
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic              error_q, error_d;
`endif

  assign accept_s   = i_valid && !buf_full_q;
  // fin_q follows i_finished every cycle, so a level left high by the previous op is not an edge.
  assign fin_rise_s = i_finished && !fin_q;

  // Next-state logic for the FSM, operand buffer and result register.
  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_a_d    = buf_a_q;
    buf_b_d    = buf_b_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    start_d    = 1'b0;
    fin_d      = i_finished;
    valid_d    = valid_q;
    product_d  = product_q;
`ifdef MULTIPLIER_SEQUENCER_TIMEOUT_EN
    cnt_d      = cnt_q;
    error_d    = error_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (buf_full_q) begin
          state_d    = S_START;
          mul_a_d    = buf_a_q;
          mul_b_d    = buf_b_q;
          start_d    = 1'b1;
          buf_full_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef MULTIPLIER_SEQUENCER_TIMEOUT_EN
        cnt_d   = {CW{1'b0}};
`endif
      end
      S_WAIT: begin
        if (fin_rise_s) begin
          state_d   = S_DONE;
          product_d = i_product;
          valid_d   = 1'b1;
`ifdef MULTIPLIER_SEQUENCER_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        end else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_DONE: begin
        if (i_ready && valid_q) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // A fresh pair wins over a pop in the same cycle.
    if (accept_s) begin
      buf_full_d = 1'b1;
      buf_a_d    = i_multiplicand;
      buf_b_d    = i_multiplier;
    end else begin
      buf_full_d = buf_full_d;
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // State and output registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      buf_full_q <= 1'b0;
      buf_a_q    <= {BITS{1'b0}};
      buf_b_q    <= {BITS{1'b0}};
      mul_a_q    <= {BITS{1'b0}};
      mul_b_q    <= {BITS{1'b0}};
      start_q    <= 1'b0;
      fin_q      <= 1'b0;
      valid_q    <= 1'b0;
      product_q  <= {(2*BITS){1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_a_q    <= buf_a_d;
      buf_b_q    <= buf_b_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      start_q    <= start_d;
      fin_q      <= fin_d;
      valid_q    <= valid_d;
      product_q  <= product_d;
      busy_q     <= busy_d;
    end
  end

`ifdef MULTIPLIER_SEQUENCER_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q   <= {CW{1'b0}};
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end
  assign o_error = error_q;
`else
  assign o_error = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

  assign o_ready            = !buf_full_q;
  assign o_start            = start_q;
  assign o_mul_multiplicand = mul_a_q;
  assign o_mul_multiplier   = mul_b_q;
  assign o_valid            = valid_q;
  assign o_product          = product_q;
  assign o_busy             = busy_q;

endmodule
